tim_apb_ctrl: RTL and testbench
===============================

Name: tim_apb_ctrl

Overview:
APB4 slave protocol controller that sequences every bus transfer into the timer register block.
- Tracks SETUP/ACCESS phases and inserts a programmable number of wait states.
- Decodes address legality and issues single-cycle wr_en/rd_en strobes with a stable latched address.
- Merges decode errors with register-side errors into tim_pslverr.
- Sits between the APB interconnect and the register file; the register file never sees raw APB phases.

Parameters:
WAIT_CYCLES, 0, wait states inserted in ACCESS before tim_pready (legal 0..15)
ADDR_MAX, 12'h01C, highest legal word address

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  synchronous active-low reset
tim_psel  in  1  APB select
tim_penable  in  1  APB enable
tim_pwrite  in  1  1=write, 0=read
tim_paddr  in  12  APB byte address
tim_pwdata  in  32  APB write data
tim_pstrb  in  4  APB byte strobes
tim_pready  out  1  transfer complete
tim_prdata  out  32  read data to bus
tim_pslverr  out  1  transfer error, valid only with tim_pready
wr_en  out  1  one-cycle write strobe to register block
rd_en  out  1  one-cycle read strobe to register block
reg_paddr  out  12  latched address to register block
reg_pwdata  out  32  latched write data
reg_pstrb  out  4  latched strobes
reg_prdata  in  32  combinational read data from register block
reg_pslverr  in  1  combinational write error from register block
prot_err  out  1  sticky APB protocol-violation flag

Behaviour:
- Reset (sys_rst_n=0 at posedge) sets:
  - state=IDLE, wait_cnt=0.
  - reg_paddr=0, reg_pwdata=0, reg_pstrb=0, latched pwrite=0.
  - prot_err=0.
  - Consequently all of tim_pready, wr_en, rd_en, tim_pslverr and tim_prdata read 0.
- Reset mid-transfer aborts the transfer; no strobe is issued.
- States: IDLE, ACCESS.
- IDLE:
  - On psel=1 & penable=0 (SETUP): latch paddr, pwdata, pstrb and pwrite; load wait_cnt=WAIT_CYCLES; go to ACCESS.
  - psel=1 & penable=1 seen in IDLE: set prot_err, stay IDLE, no pready.
- ACCESS:
  - done = psel & penable & (wait_cnt==0). Combinational: tim_pready=done.
  - psel=1, penable=1, wait_cnt!=0: decrement wait_cnt, stay in ACCESS.
  - done: return to IDLE. A back-to-back SETUP on the next cycle is accepted from IDLE, giving zero dead cycles beyond APB's own.
  - psel=0 or penable=0 in ACCESS: abort to IDLE, set prot_err, no strobe.
  - tim_paddr/tim_pwrite differing from the latched values while in ACCESS: set prot_err; the transfer still completes using the latched values.
- Address error: addr_err = reg_paddr[1:0]!=0 | reg_paddr>ADDR_MAX.
- Strobes:
  - wr_en = done & latched pwrite & ~addr_err.
  - rd_en = done & ~latched pwrite & ~addr_err.
  - Both are combinational and high for exactly the done cycle; the register block captures on that edge.
- tim_prdata = rd_en ? reg_prdata : 0.
- tim_pslverr = done & (addr_err | (latched pwrite & reg_pslverr)). Never high without tim_pready.
- Latency: total transfer = 2+WAIT_CYCLES cycles, i.e. SETUP, ACCESS, plus WAIT_CYCLES extra ACCESS cycles.
- wait_cnt is 4 bits. It cannot underflow because it only decrements when nonzero.
- prot_err clears only on reset.

Test Plan:
- WAIT_CYCLES=0, write 0x0000_0003 to 0x00 with strobe 0xF → pready on 2nd cycle; wr_en high exactly 1 cycle; reg_paddr=0x00; pslverr=0.
- WAIT_CYCLES=3, read 0x0C with reg_prdata=0xFFFF_FFFF → pready low for 3 ACCESS cycles, high on the 4th; rd_en 1 cycle; prdata=0xFFFF_FFFF only in the pready cycle, 0 otherwise.
- Write to 0x020 and read of 0x006 → pready with pslverr=1; wr_en/rd_en never assert; prdata=0.
- Write to 0x00 with reg_pslverr=1 in the done cycle → pslverr=1 with pready. Read with reg_pslverr=1 → pslverr=0.
- Back-to-back write 0x04 then read 0x08 (WAIT_CYCLES=0) → two transfers in 4 cycles; strobes on cycles 2 and 4; prot_err=0.
- psel dropped during ACCESS with WAIT_CYCLES=2 → no strobe, prot_err=1 and sticky. Reset asserted mid-ACCESS → all outputs 0 on the next cycle; prot_err=0.

Source files
------------

// File: rtl/tim_apb_ctrl.sv
// ---------------------------------------------------------------------------
// tim_apb_ctrl
//   APB4 slave protocol controller in front of the timer register block.
//   It follows SETUP/ACCESS phases, holds tim_pready low for WAIT_CYCLES
//   ACCESS cycles, latches the transfer for the register file, and issues
//   one-cycle wr_en/rd_en strobes. Address decode errors and register-side
//   write errors are merged into tim_pslverr. Protocol violations raise a
//   sticky prot_err that only reset clears.
//
// Handshake: a transfer starts with psel=1/penable=0 (SETUP). It completes in
//   the first ACCESS cycle with psel=1, penable=1 and no wait states left.
//   tim_pready, the strobes, tim_pslverr and tim_prdata are all qualified by
//   that completion cycle and are 0 in every other cycle.
//
// Ports:
//   sys_clk, sys_rst_n            clock, synchronous active-low reset
//   tim_psel/penable/pwrite       APB control
//   tim_paddr/pwdata/pstrb        APB address, write data, byte strobes
//   tim_pready/prdata/pslverr     APB response
//   wr_en, rd_en                  one-cycle strobes to the register block
//   reg_paddr/pwdata/pstrb        transfer fields latched at SETUP
//   reg_prdata, reg_pslverr       combinational response from register block
//   prot_err                      sticky protocol-violation flag
// ---------------------------------------------------------------------------
module tim_apb_ctrl #(
    parameter int          WAIT_CYCLES = 0,
    parameter logic [11:0] ADDR_MAX    = 12'h01C
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tim_psel,
    input  logic        tim_penable,
    input  logic        tim_pwrite,
    input  logic [11:0] tim_paddr,
    input  logic [31:0] tim_pwdata,
    input  logic [3:0]  tim_pstrb,
    output logic        tim_pready,
    output logic [31:0] tim_prdata,
    output logic        tim_pslverr,
    output logic        wr_en,
    output logic        rd_en,
    output logic [11:0] reg_paddr,
    output logic [31:0] reg_pwdata,
    output logic [3:0]  reg_pstrb,
    input  logic [31:0] reg_prdata,
    input  logic        reg_pslverr,
    output logic        prot_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        pwrite_q;
    logic        latch;
    logic        prot_set;
    logic        done;
    logic        addr_err;

    // State register plus the transfer fields captured at SETUP.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            reg_paddr  <= 12'd0;
            reg_pwdata <= 32'd0;
            reg_pstrb  <= 4'd0;
            pwrite_q   <= 1'b0;
            prot_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (latch) begin
                reg_paddr  <= tim_paddr;
                reg_pwdata <= tim_pwdata;
                reg_pstrb  <= tim_pstrb;
                pwrite_q   <= tim_pwrite;
            end
            if (prot_set) begin
                prot_err <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        latch      = 1'b0;
        prot_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tim_psel && !tim_penable) begin
                    latch      = 1'b1;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = ACCESS;
                end else if (tim_psel && tim_penable) begin
                    // ACCESS phase without a preceding SETUP: ignored.
                    prot_set = 1'b1;
                end
            end
            ACCESS: begin
                if (tim_psel && tim_penable) begin
                    if (wait_cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                    end
                end else begin
                    // Master abandoned the transfer; no strobe is issued.
                    state_d  = IDLE;
                    prot_set = 1'b1;
                end
                // Address/direction must hold through ACCESS; the latched
                // copies are used regardless.
                if ((tim_paddr != reg_paddr) || (tim_pwrite != pwrite_q)) begin
                    prot_set = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        done        = (state_q == ACCESS) && tim_psel && tim_penable &&
                      (wait_cnt_q == 4'd0);
        addr_err    = (reg_paddr[1:0] != 2'b00) || (reg_paddr > ADDR_MAX);
        tim_pready  = done;
        wr_en       = done && pwrite_q && !addr_err;
        rd_en       = done && !pwrite_q && !addr_err;
        tim_prdata  = rd_en ? reg_prdata : 32'd0;
        tim_pslverr = done && (addr_err || (pwrite_q && reg_pslverr));
    end

endmodule

// File: tb/tb_tim_apb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tim_apb_ctrl
//   Three controller instances with WAIT_CYCLES = 0, 3, 2 share one APB bus;
//   each has its own psel so only one is addressed at a time. Expected
//   responses come from a transfer-level model: a transfer of wait w finishes
//   on ACCESS cycle w, errors when the address is unaligned or above 0x1C (or
//   on a write with reg_pslverr), and strobes only when the address is legal.
// ---------------------------------------------------------------------------
module tb_tim_apb_ctrl;

    localparam logic [11:0] A_MAX = 12'h01C;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [2:0]  psel_v = 3'b000;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = 12'd0;
    logic [31:0] pwdata = 32'd0;
    logic [3:0]  pstrb = 4'd0;
    logic [31:0] reg_prdata = 32'd0;
    logic        reg_pslverr = 1'b0;

    logic        pready_a  [3];
    logic [31:0] prdata_a  [3];
    logic        pslverr_a [3];
    logic        wr_en_a   [3];
    logic        rd_en_a   [3];
    logic [11:0] raddr_a   [3];
    logic [31:0] rwdata_a  [3];
    logic [3:0]  rstrb_a   [3];
    logic        prot_a    [3];

    int wc[3] = '{0, 3, 2};
    bit exp_prot[3] = '{1'b0, 1'b0, 1'b0};
    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tim_apb_ctrl #(
            .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
            .ADDR_MAX   (A_MAX)
        ) u_dut (
            .sys_clk    (sys_clk),
            .sys_rst_n  (sys_rst_n),
            .tim_psel   (psel_v[g]),
            .tim_penable(penable),
            .tim_pwrite (pwrite),
            .tim_paddr  (paddr),
            .tim_pwdata (pwdata),
            .tim_pstrb  (pstrb),
            .tim_pready (pready_a[g]),
            .tim_prdata (prdata_a[g]),
            .tim_pslverr(pslverr_a[g]),
            .wr_en      (wr_en_a[g]),
            .rd_en      (rd_en_a[g]),
            .reg_paddr  (raddr_a[g]),
            .reg_pwdata (rwdata_a[g]),
            .reg_pstrb  (rstrb_a[g]),
            .reg_prdata (reg_prdata),
            .reg_pslverr(reg_pslverr),
            .prot_err   (prot_a[g])
        );
    end

    // One full transfer on instance k; chg alters paddr during ACCESS.
    task automatic xfer(input int k, input bit wr, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] rd, input bit se, input bit chg);
        int  w = wc[k];
        bit  aerr = (addr[1:0] != 2'b00) || (addr > A_MAX);
        int  strobes = 0;
        bit  last, e_wr, e_rd, e_err;
        logic [31:0] e_pr;
        @(posedge sys_clk); #1;
        psel_v = 3'b001 << k; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wd; pstrb = st; reg_prdata = rd; reg_pslverr = se;
        @(negedge sys_clk);
        checks++;
        if ({pready_a[k], wr_en_a[k], rd_en_a[k], pslverr_a[k]} !== 4'b0000) begin
            failures++;
            $display("FAIL setup_quiet k=%0d got=%b want=0000", k,
                     {pready_a[k], wr_en_a[k], rd_en_a[k], pslverr_a[k]});
        end
        for (int c = 0; c <= w; c++) begin
            @(posedge sys_clk); #1;
            penable = 1'b1;
            if (chg) paddr = addr ^ 12'h010;
            @(negedge sys_clk);
            last  = (c == w);
            e_wr  = last && wr && !aerr;
            e_rd  = last && !wr && !aerr;
            e_err = last && (aerr || (wr && se));
            e_pr  = e_rd ? rd : 32'd0;
            if (wr_en_a[k] || rd_en_a[k]) strobes++;
            checks++;
            if (pready_a[k] !== last) begin
                failures++;
                $display("FAIL pready k=%0d cyc=%0d got=%b want=%b", k, c, pready_a[k], last);
            end
            checks++;
            if ({wr_en_a[k], rd_en_a[k]} !== {e_wr, e_rd}) begin
                failures++;
                $display("FAIL strobes k=%0d cyc=%0d addr=%h got wr/rd=%b%b want=%b%b",
                         k, c, addr, wr_en_a[k], rd_en_a[k], e_wr, e_rd);
            end
            checks++;
            if (pslverr_a[k] !== e_err) begin
                failures++;
                $display("FAIL pslverr k=%0d cyc=%0d addr=%h got=%b want=%b", k, c, addr, pslverr_a[k], e_err);
            end
            checks++;
            if (prdata_a[k] !== e_pr) begin
                failures++;
                $display("FAIL prdata k=%0d cyc=%0d got=%h want=%h", k, c, prdata_a[k], e_pr);
            end
            checks++;
            if ({raddr_a[k], rwdata_a[k], rstrb_a[k]} !== {addr, wd, st}) begin
                failures++;
                $display("FAIL latched k=%0d got=%h/%h/%h want=%h/%h/%h", k,
                         raddr_a[k], rwdata_a[k], rstrb_a[k], addr, wd, st);
            end
        end
        checks++;
        if (strobes != (aerr ? 0 : 1)) begin
            failures++;
            $display("FAIL strobe_count k=%0d got=%0d want=%0d", k, strobes, aerr ? 0 : 1);
        end
        if (chg) exp_prot[k] = 1'b1;
    endtask

    // Bus idle cycle; confirms the sticky flags of every instance.
    task automatic idle();
        @(posedge sys_clk); #1;
        psel_v = 3'b000; penable = 1'b0; reg_pslverr = 1'b0;
        @(negedge sys_clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (prot_a[k] !== exp_prot[k] || pready_a[k] !== 1'b0) begin
                failures++;
                $display("FAIL idle k=%0d got prot/rdy=%b%b want=%b0", k, prot_a[k], pready_a[k], exp_prot[k]);
            end
        end
    endtask

    task automatic test_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0; psel_v = 3'b000; penable = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({pready_a[k], wr_en_a[k], rd_en_a[k], pslverr_a[k], prot_a[k]} !== 5'b0 ||
                prdata_a[k] !== 32'd0 || raddr_a[k] !== 12'd0 ||
                rwdata_a[k] !== 32'd0 || rstrb_a[k] !== 4'd0) begin
                failures++;
                $display("FAIL reset k=%0d got rdy/wr/rd/err/prot=%b prdata=%h addr=%h wdata=%h strb=%h want all 0",
                         k, {pready_a[k], wr_en_a[k], rd_en_a[k], pslverr_a[k], prot_a[k]},
                         prdata_a[k], raddr_a[k], rwdata_a[k], rstrb_a[k]);
            end
            exp_prot[k] = 1'b0;
        end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic test_basic_write();
        xfer(0, 1'b1, 12'h000, 32'h0000_0003, 4'hF, 32'h0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic test_wait_read();
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle();
    endtask

    task automatic test_addr_err();
        xfer(0, 1'b1, 12'h020, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0);
        idle();
        xfer(1, 1'b0, 12'h006, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle();
    endtask

    task automatic test_reg_err();
        xfer(0, 1'b1, 12'h000, 32'hA5A5_A5A5, 4'h3, 32'h0, 1'b1, 1'b0);
        idle();
        xfer(2, 1'b0, 12'h010, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 12'h004, 32'h5555_AAAA, 4'hC, 32'h0, 1'b0, 1'b0);
        xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, 1'b0);
        idle();
    endtask

    task automatic test_idle_enable();
        @(posedge sys_clk); #1;
        psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 12'h000;
        @(negedge sys_clk);
        checks++;
        if ({pready_a[0], wr_en_a[0], rd_en_a[0]} !== 3'b000) begin
            failures++;
            $display("FAIL idle_enable got rdy/wr/rd=%b want=000", {pready_a[0], wr_en_a[0], rd_en_a[0]});
        end
        exp_prot[0] = 1'b1;
        idle();
    endtask

    task automatic test_addr_change();
        xfer(1, 1'b1, 12'h014, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic test_abort();
        @(posedge sys_clk); #1;
        psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008;
        @(posedge sys_clk); #1;
        penable = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({pready_a[2], wr_en_a[2]} !== 2'b00) begin
            failures++;
            $display("FAIL abort_wait got rdy/wr=%b%b want=00", pready_a[2], wr_en_a[2]);
        end
        @(posedge sys_clk); #1;
        psel_v = 3'b000; penable = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({pready_a[2], wr_en_a[2], rd_en_a[2]} !== 3'b000) begin
            failures++;
            $display("FAIL abort_strobe got rdy/wr/rd=%b want=000", {pready_a[2], wr_en_a[2], rd_en_a[2]});
        end
        exp_prot[2] = 1'b1;
        idle();
        // Flag stays set across a later clean transfer.
        xfer(2, 1'b1, 12'h018, 32'h7777_0000, 4'h1, 32'h0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, 2);
            logic [11:0] a;
            if ($urandom_range(0, 1) == 1) a = 12'($urandom_range(0, 7) * 4);
            else a = 12'($urandom_range(0, 63));
            xfer(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom, 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) idle();
        end
        idle();
    endtask

    task automatic test_midreset();
        @(posedge sys_clk); #1;
        psel_v = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
        reg_prdata = 32'hFFFF_FFFF;
        @(posedge sys_clk); #1;
        penable = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0; psel_v = 3'b000; penable = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({pready_a[k], wr_en_a[k], rd_en_a[k], pslverr_a[k], prot_a[k]} !== 5'b0 ||
                prdata_a[k] !== 32'd0 || raddr_a[k] !== 12'd0) begin
                failures++;
                $display("FAIL midreset k=%0d got rdy/wr/rd/err/prot=%b prdata=%h addr=%h want 0",
                         k, {pready_a[k], wr_en_a[k], rd_en_a[k], pslverr_a[k], prot_a[k]},
                         prdata_a[k], raddr_a[k]);
            end
            exp_prot[k] = 1'b0;
        end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        idle();
        xfer(1, 1'b0, 12'h01C, 32'h0, 4'h0, 32'h2468_ACE0, 1'b0, 1'b0);
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_wait_read();
        test_addr_err();
        test_reg_err();
        test_back_to_back();
        test_idle_enable();
        test_addr_change();
        test_abort();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
